// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding and timing defaults.
// The clamp helper maps out-of-range cycle counts onto the safe value of 1.
package sram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_t;

    localparam int DEF_READ_CYCLES = 1;
    localparam int DEF_WRITE_PULSE = 1;

    function automatic logic [2:0] clamp_cycles(input int value);
        return (value < 1 || value > 7) ? 3'd1 : 3'(value);
    endfunction

endpackage

// File: rtl/sram_arbiter_wait_counter.sv
// Three-bit down counter that times the RD and WR_PULSE phases.
// Loaded with (cycles - 1); the zero flag marks the last cycle of the phase.
module sram_arbiter_wait_counter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [2:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= 3'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 3'd0)) begin
            r_count <= r_count - 3'd1;
        end
    end

    assign o_zero = (r_count == 3'd0);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one asynchronous SRAM between instruction fetch and the MEM stage,
// sequences the SRAM control pins and produces the pipeline stall signals.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int RAM_ADDR_W  = 18,
    parameter int READ_CYCLES = DEF_READ_CYCLES,
    parameter int WRITE_PULSE = DEF_WRITE_PULSE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic [DATA_W-1:0]     o_inst,
    output logic                  o_inst_valid,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [ADDR_W-1:0]     i_mem_addr,
    input  logic [DATA_W-1:0]     i_mem_wdata,
    output logic [DATA_W-1:0]     o_mem_rdata,
    output logic                  o_mem_done,
    output logic                  o_stall_if,
    output logic                  o_stall_pipe,
    output logic [RAM_ADDR_W-1:0] o_ram_addr,
    input  logic [DATA_W-1:0]     i_ram_dq_i,
    output logic [DATA_W-1:0]     o_ram_dq_o,
    output logic                  o_ram_dq_oe,
    output logic                  o_ram_ce_n,
    output logic                  o_ram_oe_n,
    output logic                  o_ram_we_n,
    output state_t                o_state
);

    localparam logic [2:0] RC = clamp_cycles(READ_CYCLES);
    localparam logic [2:0] WP = clamp_cycles(WRITE_PULSE);

    state_t                r_state;
    state_t                w_next_state;
    logic [RAM_ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0]     r_ram_dq_o;
    logic [DATA_W-1:0]     r_inst;
    logic [DATA_W-1:0]     r_mem_rdata;
    logic                  r_inst_valid;
    logic                  r_mem_done;
    logic                  r_is_inst;

    logic              w_accept;
    logic              w_sel_write;
    logic              w_sel_read;
    logic              w_sel_if;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_cnt_load;
    logic [2:0]        w_cnt_load_val;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic              w_rd_last;

    // Nothing is accepted in a done/valid cycle: the pipeline is still advancing.
    assign w_accept    = (r_state == ST_IDLE) && !r_inst_valid && !r_mem_done;
    assign w_sel_write = i_mem_write;
    assign w_sel_read  = !i_mem_write && i_mem_read;
    assign w_sel_if    = !i_mem_write && !i_mem_read && i_if_req;
    assign w_req_addr  = w_sel_if ? i_if_addr : i_mem_addr;
    assign w_rd_last   = (r_state == ST_RD) && w_cnt_zero;

    assign w_cnt_load     = (w_accept && (w_sel_read || w_sel_if)) || (r_state == ST_WR_SETUP);
    assign w_cnt_load_val = (r_state == ST_WR_SETUP) ? (WP - 3'd1) : (RC - 3'd1);
    assign w_cnt_dec      = (r_state == ST_RD) || (r_state == ST_WR_PULSE);

    sram_arbiter_wait_counter u_wait_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && w_sel_write) begin
                    w_next_state = ST_WR_SETUP;
                end else if (w_accept && (w_sel_read || w_sel_if)) begin
                    w_next_state = ST_RD;
                end
            end
            ST_RD:       if (w_cnt_zero) w_next_state = ST_IDLE;
            ST_WR_SETUP: w_next_state = ST_WR_PULSE;
            ST_WR_PULSE: if (w_cnt_zero) w_next_state = ST_WR_HOLD;
            ST_WR_HOLD:  w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // Pin decode straight from the state keeps oe_n and we_n mutually exclusive.
    always_comb begin
        o_ram_ce_n  = (r_state == ST_IDLE);
        o_ram_oe_n  = (r_state != ST_RD);
        o_ram_we_n  = (r_state != ST_WR_PULSE);
        o_ram_dq_oe = (r_state == ST_WR_SETUP) || (r_state == ST_WR_PULSE) ||
                      (r_state == ST_WR_HOLD);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ram_addr   <= '0;
            r_ram_dq_o   <= '0;
            r_inst       <= '0;
            r_mem_rdata  <= '0;
            r_inst_valid <= 1'b0;
            r_mem_done   <= 1'b0;
            r_is_inst    <= 1'b0;
        end else begin
            r_inst_valid <= 1'b0;
            r_mem_done   <= 1'b0;
            if (w_accept && (w_sel_write || w_sel_read || w_sel_if)) begin
                r_ram_addr <= RAM_ADDR_W'(w_req_addr);
                r_is_inst  <= w_sel_if;
                if (w_sel_write) begin
                    r_ram_dq_o <= i_mem_wdata;
                end
            end
            if (w_rd_last) begin
                if (r_is_inst) begin
                    r_inst       <= i_ram_dq_i;
                    r_inst_valid <= 1'b1;
                end else begin
                    r_mem_rdata <= i_ram_dq_i;
                    r_mem_done  <= 1'b1;
                end
            end
            if (r_state == ST_WR_HOLD) begin
                r_mem_done <= 1'b1;
            end
        end
    end

    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_mem_rdata  = r_mem_rdata;
    assign o_mem_done   = r_mem_done;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_dq_o   = r_ram_dq_o;
    assign o_state      = r_state;

    assign o_stall_pipe = (i_mem_read | i_mem_write) & ~r_mem_done;
    assign o_stall_if   = o_stall_pipe | (i_if_req & ~r_inst_valid);

endmodule
